thcattus_uart_rx: RTL

THCATTUS_UART_RX -- requirements
Module: thcattus_uart_rx

---
 rtl/thcattus_uart_rx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/thcattus_uart_rx.sv
// UART 8N1 receiver that assembles DATA_WIDTH bytes into one AXI-Stream beat.
// Partial words are dropped on framing errors, on long inter-byte gaps and on reset.
module thcattus_uart_rx #(
    parameter int DATA_WIDTH       = 12,
    parameter int CLOCK_FREQ       = 50_000_000,
    parameter int BAUD_RATE        = 115200,
    parameter int GAP_TIMEOUT_BITS = 16
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic                    uart_rx,
    output logic                    axis_tvalid,
    input  logic                    axis_tready,
    output logic [DATA_WIDTH*8-1:0] axis_tdata,
    output logic                    frame_err,
    output logic                    overrun_err
);

    localparam int CYCLE_PER_BAUD = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF           = CYCLE_PER_BAUD / 2;
    localparam int GAP_LIMIT      = GAP_TIMEOUT_BITS * CYCLE_PER_BAUD;
    localparam int CNT_W          = $clog2(CYCLE_PER_BAUD + 1);
    localparam int GAP_W          = $clog2(GAP_LIMIT + 1);
    localparam int BC_W           = $clog2(DATA_WIDTH + 1);
    localparam int WORD_W         = DATA_WIDTH * 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_sync;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift_reg;
    logic [BC_W-1:0]    byte_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [WORD_W-1:0]  asm_buf;
    logic [WORD_W-1:0]  asm_next;
    logic               word_done;

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Assembly buffer as it will look once the byte now in shift_reg is accepted
    always_comb begin
        asm_next = asm_buf;
        asm_next[int'(byte_cnt)*8 +: 8] = shift_reg;
    end

    assign word_done = (byte_cnt == BC_W'(DATA_WIDTH - 1));

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            axis_tvalid <= 1'b0;
            axis_tdata  <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            if (axis_tvalid && axis_tready)
                axis_tvalid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_sync) begin
                        state   <= ST_START;
                        gap_cnt <= '0;
                    end else if (byte_cnt != '0) begin
                        // Line went quiet mid-word: resynchronise silently
                        if (gap_cnt == GAP_W'(GAP_LIMIT - 1)) begin
                            byte_cnt <= '0;
                            gap_cnt  <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end else begin
                        gap_cnt <= '0;
                    end
                end

                ST_START: begin
                    if (baud_cnt == CNT_W'(HALF - 1)) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (baud_cnt == CNT_W'(CYCLE_PER_BAUD - 1)) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (baud_cnt == CNT_W'(CYCLE_PER_BAUD - 1)) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                        if (rx_sync) begin
                            asm_buf <= asm_next;
                            if (word_done) begin
                                byte_cnt <= '0;
                                // A pending beat that is not being taken wins over the new word
                                if (axis_tvalid && !axis_tready) begin
                                    overrun_err <= 1'b1;
                                end else begin
                                    axis_tdata  <= asm_next;
                                    axis_tvalid <= 1'b1;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            byte_cnt  <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
